axi_riscv_lrsc_initiator: RTL and testbench

Master-side counterpart of the LR/SC adapter. It converts a simple single-outstanding core request port (load, store, LR, SC) into single-beat AXI4 transactions. LR is issued as an exclusive read (ar_lock=1) and SC as an exclusive write (aw_lock=1). B/R responses are interpreted as success, SC-failure or error. The block sits between a core or DMA load/store unit and the AXI interconnect that contains the LR/SC adapter.

---
 rtl/axi_riscv_lrsc_initiator.sv | 260 ++++++++++++++++++++++++++
 tb/tb_axi_riscv_lrsc_initiator.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_riscv_lrsc_initiator.sv
// Single-outstanding load/store/LR/SC requester on single-beat AXI4.
// LR maps to an exclusive read, SC to an exclusive write.
module axi_riscv_lrsc_initiator #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ID         = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [1:0]                  req_op_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [2:0]                  req_size_i,
    input  logic [AXI_DATA_WIDTH-1:0]   req_wdata_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                        rsp_err_o,
    output logic                        rsp_sc_fail_o,
    output logic [AXI_ADDR_WIDTH-1:0]   mst_ar_addr_o,
    output logic [2:0]                  mst_ar_size_o,
    output logic                        mst_ar_lock_o,
    output logic [AXI_ID_WIDTH-1:0]     mst_ar_id_o,
    output logic                        mst_ar_valid_o,
    input  logic                        mst_ar_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0]   mst_aw_addr_o,
    output logic [2:0]                  mst_aw_size_o,
    output logic                        mst_aw_lock_o,
    output logic [AXI_ID_WIDTH-1:0]     mst_aw_id_o,
    output logic                        mst_aw_valid_o,
    input  logic                        mst_aw_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]   mst_w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0] mst_w_strb_o,
    output logic                        mst_w_last_o,
    output logic                        mst_w_valid_o,
    input  logic                        mst_w_ready_i,
    input  logic [AXI_DATA_WIDTH-1:0]   mst_r_data_i,
    input  logic [1:0]                  mst_r_resp_i,
    input  logic                        mst_r_last_i,
    input  logic [AXI_ID_WIDTH-1:0]     mst_r_id_i,
    input  logic                        mst_r_valid_i,
    output logic                        mst_r_ready_o,
    input  logic [1:0]                  mst_b_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]     mst_b_id_i,
    input  logic                        mst_b_valid_i,
    output logic                        mst_b_ready_o
);

    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int OFF_W =
        (AXI_STRB_WIDTH > 1) ? $clog2(AXI_STRB_WIDTH) : 1;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(AXI_STRB_WIDTH));
    localparam logic [AXI_ID_WIDTH-1:0] ID = AXI_ID_WIDTH'(AXI_ID);

    localparam logic [1:0] OP_LR     = 2'b10;
    localparam logic [1:0] OP_SC     = 2'b11;
    localparam logic [1:0] RESP_EXOK = 2'b01;

    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

    state_t                      state;
    logic [1:0]                  op_q;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [2:0]                  size_q;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [AXI_STRB_WIDTH-1:0]   strb_q;
    logic                        ar_valid_q;
    logic                        aw_valid_q;
    logic                        w_valid_q;
    logic                        r_ready_q;
    logic                        b_ready_q;
    logic                        aw_done_q;
    logic                        w_done_q;
    logic                        rsp_valid_q;
    logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                        rsp_err_q;
    logic                        rsp_sc_fail_q;
    logic                        resv_valid_q;
    logic [AXI_ADDR_WIDTH-1:0]   resv_addr_q;

    logic [AXI_ADDR_WIDTH-1:0]   align_mask;
    logic                        req_bad;
    logic                        req_sc_miss;
    logic                        r_err;
    logic                        r_exok;
    logic                        b_err;
    logic                        b_exok;
    logic                        aw_fin;
    logic                        w_fin;

    function automatic logic [AXI_STRB_WIDTH-1:0] lane_strb(
        input logic [AXI_ADDR_WIDTH-1:0] addr,
        input logic [2:0]                size
    );
        logic [AXI_STRB_WIDTH-1:0] strb;
        int off;
        int len;
        strb = '0;
        off  = (AXI_STRB_WIDTH > 1) ? int'(addr[OFF_W-1:0]) : 0;
        len  = 1 << size;
        for (int i = 0; i < AXI_STRB_WIDTH; i++)
            strb[i] = (i >= off) && (i < off + len);
        return strb;
    endfunction

    always_comb begin
        align_mask  = AXI_ADDR_WIDTH'((32'd1 << req_size_i) - 32'd1);
        req_bad     = (req_size_i > MAX_SIZE) ||
                      ((req_addr_i & align_mask) != '0);
        req_sc_miss = (req_op_i == OP_SC) &&
                      (!resv_valid_q || (req_addr_i != resv_addr_q));
    end

    // ID or last mismatches are protocol errors, treated like bus errors
    assign r_err  = mst_r_resp_i[1] || !mst_r_last_i ||
                    (mst_r_id_i != ID);
    assign r_exok = (mst_r_resp_i == RESP_EXOK);
    assign b_err  = mst_b_resp_i[1] || (mst_b_id_i != ID);
    assign b_exok = (mst_b_resp_i == RESP_EXOK);
    assign aw_fin = aw_done_q || (aw_valid_q && mst_aw_ready_i);
    assign w_fin  = w_done_q || (w_valid_q && mst_w_ready_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            op_q          <= '0;
            addr_q        <= '0;
            size_q        <= '0;
            wdata_q       <= '0;
            strb_q        <= '0;
            ar_valid_q    <= 1'b0;
            aw_valid_q    <= 1'b0;
            w_valid_q     <= 1'b0;
            r_ready_q     <= 1'b0;
            b_ready_q     <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_sc_fail_q <= 1'b0;
            resv_valid_q  <= 1'b0;
            resv_addr_q   <= '0;
        end else begin
            unique case (state)
                IDLE: if (req_valid_i) begin
                    op_q          <= req_op_i;
                    addr_q        <= req_addr_i;
                    size_q        <= req_size_i;
                    wdata_q       <= req_wdata_i;
                    strb_q        <= lane_strb(req_addr_i, req_size_i);
                    rsp_rdata_q   <= '0;
                    rsp_err_q     <= 1'b0;
                    rsp_sc_fail_q <= 1'b0;
                    if (req_op_i == OP_SC)
                        resv_valid_q <= 1'b0;
                    if (req_bad) begin
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state       <= RSP;
                    end else if (req_sc_miss) begin
                        rsp_sc_fail_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state         <= RSP;
                    end else if (!req_op_i[0]) begin
                        ar_valid_q <= 1'b1;
                        state      <= RD;
                    end else begin
                        aw_valid_q <= 1'b1;
                        w_valid_q  <= 1'b1;
                        aw_done_q  <= 1'b0;
                        w_done_q   <= 1'b0;
                        state      <= WR;
                    end
                end
                RD: begin
                    if (ar_valid_q && mst_ar_ready_i) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                    end
                    if (r_ready_q && mst_r_valid_i) begin
                        r_ready_q   <= 1'b0;
                        rsp_rdata_q <= mst_r_data_i;
                        rsp_valid_q <= 1'b1;
                        state       <= RSP;
                        if (op_q == OP_LR) begin
                            rsp_err_q     <= r_err;
                            rsp_sc_fail_q <= r_err || !r_exok;
                            resv_valid_q  <= !r_err && r_exok;
                            resv_addr_q   <= addr_q;
                        end else begin
                            rsp_err_q <= r_err || r_exok;
                        end
                    end
                end
                WR: begin
                    if (aw_valid_q && mst_aw_ready_i) begin
                        aw_valid_q <= 1'b0;
                        aw_done_q  <= 1'b1;
                    end
                    if (w_valid_q && mst_w_ready_i) begin
                        w_valid_q <= 1'b0;
                        w_done_q  <= 1'b1;
                    end
                    if (b_ready_q && mst_b_valid_i) begin
                        b_ready_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= RSP;
                        if (op_q == OP_SC) begin
                            rsp_err_q     <= b_err;
                            rsp_sc_fail_q <= b_err || !b_exok;
                        end else begin
                            rsp_err_q <= b_err || b_exok;
                            // a plain store to the reserved line kills it
                            if (!b_err && !b_exok &&
                                addr_q == resv_addr_q)
                                resv_valid_q <= 1'b0;
                        end
                    end else if (aw_fin && w_fin) begin
                        b_ready_q <= 1'b1;
                    end
                end
                RSP: if (rsp_ready_i) begin
                    rsp_valid_q <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready_o    = (state == IDLE);
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_rdata_o    = rsp_rdata_q;
    assign rsp_err_o      = rsp_err_q;
    assign rsp_sc_fail_o  = rsp_sc_fail_q;

    assign mst_ar_addr_o  = addr_q;
    assign mst_ar_size_o  = size_q;
    assign mst_ar_lock_o  = (op_q == OP_LR);
    assign mst_ar_id_o    = ID;
    assign mst_ar_valid_o = ar_valid_q;

    assign mst_aw_addr_o  = addr_q;
    assign mst_aw_size_o  = size_q;
    assign mst_aw_lock_o  = (op_q == OP_SC);
    assign mst_aw_id_o    = ID;
    assign mst_aw_valid_o = aw_valid_q;

    assign mst_w_data_o   = wdata_q;
    assign mst_w_strb_o   = strb_q;
    assign mst_w_last_o   = 1'b1;
    assign mst_w_valid_o  = w_valid_q;

    assign mst_r_ready_o  = r_ready_q;
    assign mst_b_ready_o  = b_ready_q;

endmodule

// File: tb/tb_axi_riscv_lrsc_initiator.sv
// Bench for axi_riscv_lrsc_initiator: directed plan plus random traffic
// against a reservation/response model driven from the bench.
module tb_axi_riscv_lrsc_initiator;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int ID = 5;

    localparam logic [1:0] LOAD  = 2'b00;
    localparam logic [1:0] STORE = 2'b01;
    localparam logic [1:0] LR    = 2'b10;
    localparam logic [1:0] SC    = 2'b11;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [1:0]    req_op_i;
    logic [AW-1:0] req_addr_i;
    logic [2:0]    req_size_i;
    logic [DW-1:0] req_wdata_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic          rsp_sc_fail_o;
    logic [AW-1:0] ar_addr;
    logic [2:0]    ar_size;
    logic          ar_lock;
    logic [IW-1:0] ar_id;
    logic          ar_valid;
    logic          ar_ready;
    logic [AW-1:0] aw_addr;
    logic [2:0]    aw_size;
    logic          aw_lock;
    logic [IW-1:0] aw_id;
    logic          aw_valid;
    logic          aw_ready;
    logic [DW-1:0] w_data;
    logic [7:0]    w_strb;
    logic          w_last;
    logic          w_valid;
    logic          w_ready;
    logic [DW-1:0] r_data;
    logic [1:0]    r_resp;
    logic          r_last;
    logic [IW-1:0] r_id;
    logic          r_valid;
    logic          r_ready;
    logic [1:0]    b_resp;
    logic [IW-1:0] b_id;
    logic          b_valid;
    logic          b_ready;

    int checks = 0;
    int errors = 0;

    logic          m_resv_valid;
    logic [AW-1:0] m_resv_addr;

    always #5 clk = ~clk;

    axi_riscv_lrsc_initiator #(
        .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW),
        .AXI_ID_WIDTH  (IW),
        .AXI_ID        (ID)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_op_i      (req_op_i),
        .req_addr_i    (req_addr_i),
        .req_size_i    (req_size_i),
        .req_wdata_i   (req_wdata_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_sc_fail_o (rsp_sc_fail_o),
        .mst_ar_addr_o (ar_addr),
        .mst_ar_size_o (ar_size),
        .mst_ar_lock_o (ar_lock),
        .mst_ar_id_o   (ar_id),
        .mst_ar_valid_o(ar_valid),
        .mst_ar_ready_i(ar_ready),
        .mst_aw_addr_o (aw_addr),
        .mst_aw_size_o (aw_size),
        .mst_aw_lock_o (aw_lock),
        .mst_aw_id_o   (aw_id),
        .mst_aw_valid_o(aw_valid),
        .mst_aw_ready_i(aw_ready),
        .mst_w_data_o  (w_data),
        .mst_w_strb_o  (w_strb),
        .mst_w_last_o  (w_last),
        .mst_w_valid_o (w_valid),
        .mst_w_ready_i (w_ready),
        .mst_r_data_i  (r_data),
        .mst_r_resp_i  (r_resp),
        .mst_r_last_i  (r_last),
        .mst_r_id_i    (r_id),
        .mst_r_valid_i (r_valid),
        .mst_r_ready_o (r_ready),
        .mst_b_resp_i  (b_resp),
        .mst_b_id_i    (b_id),
        .mst_b_valid_i (b_valid),
        .mst_b_ready_o (b_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs,
                        input logic exp);
        chk(tag, 64'(obs), 64'(exp));
    endtask

    // One request, with the bench acting as the AXI slave.
    task automatic txn(
        input logic [1:0]  op,
        input logic [31:0] addr,
        input logic [2:0]  size,
        input logic [63:0] wdata,
        input logic [1:0]  resp,
        input logic [63:0] rdata,
        input bit          last_ok,
        input bit          id_ok,
        input int          ar_dly,
        input int          aw_dly,
        input int          w_dly,
        input int          rsp_dly
    );
        int         n_bytes;
        logic       loc_err;
        logic       loc_fail;
        logic       exp_err;
        logic       exp_fail;
        logic [7:0] exp_strb;
        bit         aw_ok;
        bit         w_ok;
        bit         aw_hs;
        bit         w_hs;
        bit         got_b;
        bit         excl;
        bit         bus_err;

        n_bytes  = 1 << size;
        excl     = op[1];
        loc_err  = (size > 3'd3) ||
                   ((addr & 32'(n_bytes - 1)) != 32'd0);
        loc_fail = !loc_err && op == SC &&
                   !(m_resv_valid && m_resv_addr == addr);
        exp_strb = 8'(((1 << n_bytes) - 1) << addr[2:0]);
        if (op == SC)
            m_resv_valid = 1'b0;

        @(negedge clk);
        chk1("req_ready before req", req_ready_o, 1'b1);
        chk1("rsp_valid before req", rsp_valid_o, 1'b0);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_addr_i  = addr;
        req_size_i  = size;
        req_wdata_i = wdata;
        @(negedge clk);
        req_valid_i = 1'b0;
        exp_err  = loc_err;
        exp_fail = loc_fail;

        if (loc_err || loc_fail) begin
            chk1("local rsp at cycle 1", rsp_valid_o, 1'b1);
            chk1("no ar on local", ar_valid, 1'b0);
            chk1("no aw on local", aw_valid, 1'b0);
        end else if (!op[0]) begin
            chk1("ar_valid cycle 1", ar_valid, 1'b1);
            chk1("r_ready before ar", r_ready, 1'b0);
            chk("ar_addr", 64'(ar_addr), 64'(addr));
            chk("ar_size", 64'(ar_size), 64'(size));
            chk1("ar_lock", ar_lock, op == LR);
            chk("ar_id", 64'(ar_id), 64'(ID));
            for (int k = 0; k < ar_dly; k++) begin
                @(negedge clk);
                chk1("ar_valid held", ar_valid, 1'b1);
            end
            ar_ready = 1'b1;
            @(negedge clk);
            ar_ready = 1'b0;
            chk1("ar_valid drop", ar_valid, 1'b0);
            chk1("r_ready after ar", r_ready, 1'b1);
            r_valid = 1'b1;
            r_resp  = resp;
            r_data  = rdata;
            r_last  = last_ok;
            r_id    = id_ok ? IW'(ID) : IW'(ID + 1);
            @(negedge clk);
            r_valid = 1'b0;
            chk1("rsp after r", rsp_valid_o, 1'b1);
            bus_err  = resp[1] || !last_ok || !id_ok;
            exp_err  = bus_err || (!excl && resp == 2'b01);
            exp_fail = excl && (bus_err || resp != 2'b01);
            if (op == LR) begin
                m_resv_valid = !bus_err && resp == 2'b01;
                m_resv_addr  = addr;
            end
            chk("rdata", rsp_rdata_o, rdata);
        end else begin
            chk1("aw_valid cycle 1", aw_valid, 1'b1);
            chk1("w_valid cycle 1", w_valid, 1'b1);
            chk("aw_size", 64'(aw_size), 64'(size));
            chk1("aw_lock", aw_lock, op == SC);
            chk("aw_id", 64'(aw_id), 64'(ID));
            chk("w_strb", 64'(w_strb), 64'(exp_strb));
            chk("w_data", w_data, wdata);
            chk1("w_last", w_last, 1'b1);
            aw_ok = 0;
            w_ok  = 0;
            got_b = 0;
            for (int k = 0; k < 40; k++) begin
                if (b_ready) begin
                    got_b = 1;
                    break;
                end
                chk1("aw_valid until hs", aw_valid, !aw_ok);
                chk1("w_valid until hs", w_valid, !w_ok);
                if (!aw_ok)
                    chk("aw_addr stable", 64'(aw_addr), 64'(addr));
                aw_ready = !aw_ok && k >= aw_dly;
                w_ready  = !w_ok && k >= w_dly;
                aw_hs    = aw_ready && aw_valid;
                w_hs     = w_ready && w_valid;
                @(negedge clk);
                aw_ok    = aw_ok || aw_hs;
                w_ok     = w_ok || w_hs;
                aw_ready = 1'b0;
                w_ready  = 1'b0;
            end
            chk1("b_ready within bound", got_b, 1'b1);
            if (got_b) begin
                chk1("b_ready after aw and w", aw_ok && w_ok, 1'b1);
                b_valid = 1'b1;
                b_resp  = resp;
                b_id    = id_ok ? IW'(ID) : IW'(ID + 1);
                @(negedge clk);
                b_valid = 1'b0;
                chk1("rsp after b", rsp_valid_o, 1'b1);
                bus_err  = resp[1] || !id_ok;
                exp_err  = bus_err || (!excl && resp == 2'b01);
                exp_fail = excl && (bus_err || resp != 2'b01);
                if (op == STORE && resp == 2'b00 && id_ok &&
                    addr == m_resv_addr)
                    m_resv_valid = 1'b0;
            end
        end

        for (int k = 0; k < rsp_dly; k++) begin
            @(negedge clk);
            chk1("rsp_valid held", rsp_valid_o, 1'b1);
            chk1("req_ready low in rsp", req_ready_o, 1'b0);
        end
        chk1("rsp_err", rsp_err_o, exp_err);
        chk1("rsp_sc_fail", rsp_sc_fail_o, exp_fail);
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        chk1("rsp_valid drop", rsp_valid_o, 1'b0);
        chk1("req_ready back", req_ready_o, 1'b1);
    endtask

    initial begin
        logic [31:0] pool [4];
        logic [1:0]  op;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  resp;

        pool[0] = 32'h100;
        pool[1] = 32'h108;
        pool[2] = 32'h200;
        pool[3] = 32'h00A;

        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_op_i    = '0;
        req_addr_i  = '0;
        req_size_i  = '0;
        req_wdata_i = '0;
        rsp_ready_i = 1'b0;
        ar_ready    = 1'b0;
        aw_ready    = 1'b0;
        w_ready     = 1'b0;
        r_data      = '0;
        r_resp      = '0;
        r_last      = 1'b0;
        r_id        = '0;
        r_valid     = 1'b0;
        b_resp      = '0;
        b_id        = '0;
        b_valid     = 1'b0;
        m_resv_valid = 1'b0;
        m_resv_addr  = '0;

        repeat (2) @(negedge clk);
        chk1("reset req_ready", req_ready_o, 1'b1);
        chk1("reset rsp_valid", rsp_valid_o, 1'b0);
        chk1("reset ar_valid", ar_valid, 1'b0);
        chk1("reset aw_valid", aw_valid, 1'b0);
        chk1("reset w_valid", w_valid, 1'b0);
        chk1("reset r_ready", r_ready, 1'b0);
        chk1("reset b_ready", b_ready, 1'b0);
        chk1("reset rsp_err", rsp_err_o, 1'b0);
        chk1("reset rsp_sc_fail", rsp_sc_fail_o, 1'b0);
        chk("reset rsp_rdata", rsp_rdata_o, 64'h0);
        rst_i = 1'b0;

        // LR grant, SC success, repeated SC fails locally
        txn(LR, 32'h100, 3'd3, 64'h0, 2'b01, 64'hDEAD,
            1, 1, 0, 0, 0, 0);
        txn(SC, 32'h100, 3'd3, 64'h1234_5678_9ABC_DEF0, 2'b01,
            64'h0, 1, 1, 0, 0, 0, 0);
        txn(SC, 32'h100, 3'd3, 64'h1, 2'b01, 64'h0,
            1, 1, 0, 0, 0, 0);
        // SC to a different address, then reservation is gone
        txn(LR, 32'h100, 3'd3, 64'h0, 2'b01, 64'h55,
            1, 1, 1, 0, 0, 1);
        txn(SC, 32'h108, 3'd3, 64'h2, 2'b01, 64'h0,
            1, 1, 0, 0, 0, 0);
        txn(SC, 32'h100, 3'd3, 64'h3, 2'b01, 64'h0,
            1, 1, 0, 0, 0, 0);
        // halfword store, W accepted before a slow AW
        txn(STORE, 32'h0A, 3'd1, 64'h0000_0000_BEEF_0000, 2'b00,
            64'h0, 1, 1, 0, 3, 0, 0);
        // SLVERR load and oversize load
        txn(LOAD, 32'h40, 3'd3, 64'h0, 2'b10, 64'hCAFE,
            1, 1, 0, 0, 0, 0);
        txn(LOAD, 32'h40, 3'd4, 64'h0, 2'b00, 64'h0,
            1, 1, 0, 0, 0, 0);
        // store to the reserved line clears it; LR not granted
        txn(LR, 32'h200, 3'd2, 64'h0, 2'b01, 64'h77,
            1, 1, 0, 0, 0, 0);
        txn(STORE, 32'h200, 3'd2, 64'h9, 2'b00, 64'h0,
            1, 1, 0, 1, 2, 0);
        txn(SC, 32'h200, 3'd2, 64'h9, 2'b01, 64'h0,
            1, 1, 0, 0, 0, 0);
        txn(LR, 32'h300, 3'd3, 64'h0, 2'b00, 64'h88,
            1, 1, 0, 0, 0, 0);

        // reset while AW is pending
        txn(LR, 32'h300, 3'd3, 64'h0, 2'b01, 64'h99,
            1, 1, 0, 0, 0, 0);
        @(negedge clk);
        req_valid_i = 1'b1;
        req_op_i    = STORE;
        req_addr_i  = 32'h40;
        req_size_i  = 3'd3;
        @(negedge clk);
        req_valid_i = 1'b0;
        chk1("aw pending before reset", aw_valid, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        chk1("aw_valid drops in reset", aw_valid, 1'b0);
        chk1("w_valid drops in reset", w_valid, 1'b0);
        chk1("req_ready in reset", req_ready_o, 1'b1);
        @(negedge clk);
        rst_i = 1'b0;
        m_resv_valid = 1'b0;
        @(negedge clk);
        chk1("req_ready after reset", req_ready_o, 1'b1);
        txn(SC, 32'h300, 3'd3, 64'h5, 2'b01, 64'h0,
            1, 1, 0, 0, 0, 0);

        // random traffic against the model
        for (int n = 0; n < 120; n++) begin
            op   = 2'($urandom_range(0, 3));
            addr = pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0)
                addr = addr + 32'($urandom_range(1, 3));
            size = ($urandom_range(0, 9) == 0) ? 3'd4
                   : 3'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                resp = 2'($urandom_range(0, 3));
            else
                resp = op[1] ? 2'b01 : 2'b00;
            txn(op, addr, size,
                {32'($urandom), 32'($urandom)}, resp,
                {32'($urandom), 32'($urandom)},
                $urandom_range(0, 15) != 0,
                $urandom_range(0, 15) != 0,
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
